// File: rtl/sym_ex_pkg.sv
// Shared types for the symbolic-execution round-robin scheduler: program
// locations, step constants and the per-location step decision helper.
package sym_ex_pkg;

  typedef enum logic [2:0] {
    LOC0 = 3'd0, LOC1 = 3'd1, LOC2 = 3'd2, LOC3 = 3'd3,
    LOC4 = 3'd4, LOC5 = 3'd5, LOC6 = 3'd6, LOC7 = 3'd7
  } loc_e;

  localparam int unsigned B_LIM   = 5;
  localparam int unsigned X_SET   = 3;
  localparam int unsigned Y_SET   = 2;
  localparam int unsigned Z_SET   = 2;
  localparam int unsigned SUM_BAD = 4;

  // What one granted step does, independent of data width.
  typedef struct packed {
    loc_e nxt;
    logic set_x;
    logic set_y;
    logic set_z;
    logic hit_err;
  } step_t;

  function automatic step_t step_fn(input loc_e loc, input logic a_nz, input logic b_lt,
                                    input logic c_nz, input logic sum_bad);
    step_t s;
    s.nxt     = loc;
    s.set_x   = 1'b0;
    s.set_y   = 1'b0;
    s.set_z   = 1'b0;
    s.hit_err = 1'b0;
    case (loc)
      LOC0: s.nxt = LOC1;
      LOC1: begin s.set_x = a_nz; s.nxt = LOC2; end
      LOC2: s.nxt = b_lt ? LOC3 : LOC5;
      LOC3: begin s.set_y = ~a_nz & c_nz; s.nxt = LOC4; end
      LOC4: begin s.set_z = 1'b1; s.nxt = LOC5; end
      LOC5: begin s.nxt = sum_bad ? LOC7 : LOC6; s.hit_err = sum_bad; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sym_ex_rr_sched_if.sv
// Request/grant bundle of the scheduler. step_cnt exists only when
// SYM_EX_STEP_CNT_EN is defined.
interface sym_ex_rr_sched_if #(
  parameter int NTHR = 4,
  parameter int W    = 8
) ();
  // Handshake: req[i] asks for one step; gnt is combinational and one-hot,
  // and a step is committed at the rising edge that follows a cycle with gnt[i]=1.
  logic [NTHR-1:0]   req;
  logic [NTHR-1:0]   clr;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [W-1:0]      c;
  logic [NTHR-1:0]   gnt;
  logic              gnt_vld;
  logic [3*NTHR-1:0] loc_o;
  logic [NTHR-1:0]   done;
  logic              err;
`ifdef SYM_EX_STEP_CNT_EN
  logic [16*NTHR-1:0] step_cnt;
`endif

  modport master (
    output req, clr, a, b, c,
`ifdef SYM_EX_STEP_CNT_EN
    input  step_cnt,
`endif
    input  gnt, gnt_vld, loc_o, done, err
  );

  modport slave (
    input  req, clr, a, b, c,
`ifdef SYM_EX_STEP_CNT_EN
    output step_cnt,
`endif
    output gnt, gnt_vld, loc_o, done, err
  );
endinterface

// File: rtl/sym_ex_rr_arb.sv
// Rotating-priority arbiter: grants the first eligible index after ptr.
module sym_ex_rr_arb #(
  parameter int NTHR = 4,
  parameter int PW   = 2
) (
  input  logic [NTHR-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NTHR-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NTHR; k++) begin
      idx = PW'((int'(ptr) + k) % NTHR);
      if (!found && eligible[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end
endmodule

// File: rtl/sym_ex_rr_sched.sv
// Round-robin scheduler sharing one symbolic-execution step among NTHR contexts.
// Defining SYM_EX_STEP_CNT_EN adds per-thread saturating grant counters.
module sym_ex_rr_sched
  import sym_ex_pkg::*;
#(
  parameter int NTHR = 4,
  parameter int W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  sym_ex_rr_sched_if.slave bus
);
  localparam int PW = (NTHR > 1) ? $clog2(NTHR) : 1;

  logic [NTHR-1:0][2:0]   loc_q, loc_d;
  logic [NTHR-1:0][W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [PW-1:0]          ptr_q, ptr_d, gnt_idx;
  logic                   err_q, err_d;
  logic [NTHR-1:0]        done_w, eligible, gnt;
  step_t                  st;
  logic [W-1:0]           sum;

  always_comb begin
    done_w = '0;
    for (int i = 0; i < NTHR; i++) done_w[i] = (loc_q[i][2:1] == 2'b11);
  end

  // Reset gating keeps gnt quiet while rst_n is low.
  assign eligible = bus.req & ~bus.clr & ~done_w & {NTHR{rst_n}};

  sym_ex_rr_arb #(.NTHR(NTHR), .PW(PW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    loc_d = loc_q;
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    err_d = err_q;
    ptr_d = ptr_q;
    st    = '0;
    sum   = '0;
    if (|gnt) ptr_d = gnt_idx;
    for (int i = 0; i < NTHR; i++) begin
      if (bus.clr[i]) begin
        loc_d[i] = LOC0;
        x_d[i]   = '0;
        y_d[i]   = '0;
        z_d[i]   = '0;
      end else if (gnt[i]) begin
        sum = x_q[i] + y_q[i];
        st  = step_fn(loc_e'(loc_q[i]), |bus.a, bus.b < W'(B_LIM), |bus.c,
                      sum == W'(SUM_BAD));
        loc_d[i] = st.nxt;
        if (st.set_x)   x_d[i] = W'(X_SET);
        if (st.set_y)   y_d[i] = W'(Y_SET);
        if (st.set_z)   z_d[i] = W'(Z_SET);
        if (st.hit_err) err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      ptr_q <= PW'(NTHR - 1);
      err_q <= 1'b0;
    end else begin
      loc_q <= loc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

`ifdef SYM_EX_STEP_CNT_EN
  logic [NTHR-1:0][15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NTHR; i++) begin
        if (bus.clr[i])                           cnt_q[i] <= '0;
        else if (gnt[i] && cnt_q[i] != 16'hFFFF)  cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign bus.step_cnt = cnt_q;
`endif

  assign bus.gnt     = gnt;
  assign bus.gnt_vld = |gnt;
  assign bus.loc_o   = loc_q;
  assign bus.done    = done_w;
  assign bus.err     = err_q;
endmodule
